// File: rtl/bpf_pkg.sv
// Shared BPF definitions: instruction/code-RAM geometry and the loader FSM state encoding.
package bpf_pkg;

    localparam int unsigned INST_WIDTH      = 64;
    localparam int unsigned CODE_ADDR_WIDTH = 10;
    localparam int unsigned LOAD_WORD_WIDTH = 32;

    typedef enum logic [2:0] {
        StIdle,
        StHi,
        StLo,
        StDone,
        StErr
    } loader_state_e;

endpackage

// File: rtl/bpf_code_loader_if.sv
// Program-word stream into the code loader (valid/ready with last-word marker).
interface bpf_code_loader_if #(
    parameter int unsigned IN_WIDTH = 32
);

    logic [IN_WIDTH-1:0] s_data;
    logic                s_valid;
    logic                s_last;
    logic                s_ready;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready
    );

endinterface

// File: rtl/bpf_code_loader.sv
// Pairs 32-bit program words into 64-bit instructions and writes them to the code RAM from 0.
// Optional running XOR of accepted words when BPF_LOADER_CHECKSUM_EN is defined.
module bpf_code_loader
    import bpf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = CODE_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = INST_WIDTH,
    parameter int unsigned IN_WIDTH   = LOAD_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    bpf_code_loader_if.slave      prog,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   inst_cnt
`ifdef BPF_LOADER_CHECKSUM_EN
    ,
    output logic [IN_WIDTH-1:0]   checksum
`endif
);

    localparam logic [ADDR_WIDTH:0] LastSlot = (ADDR_WIDTH + 1)'((1 << ADDR_WIDTH) - 1);
    localparam logic [ADDR_WIDTH:0] CntOne   = (ADDR_WIDTH + 1)'(1);

    if (DATA_WIDTH != 2 * IN_WIDTH) begin : g_bad_width
        $error("bpf_code_loader: DATA_WIDTH must equal 2*IN_WIDTH");
    end

    loader_state_e         state_q, state_d;
    logic [IN_WIDTH-1:0]   hi_q, hi_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  wr_en_q, wr_en_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH:0]   inst_cnt_q, inst_cnt_d;
    logic                  accept;

    assign busy         = (state_q == StHi) || (state_q == StLo);
    // load_start wins over a word offered in the same cycle
    assign prog.s_ready = busy && !load_start;
    assign accept       = prog.s_valid && prog.s_ready;

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        done_d     = done_q;
        err_d      = err_q;
        inst_cnt_d = inst_cnt_q;

        if (load_start) begin
            state_d    = StHi;
            inst_cnt_d = '0;
            done_d     = 1'b0;
            err_d      = 1'b0;
        end else begin
            unique case (state_q)
                StHi: begin
                    if (accept) begin
                        hi_d = prog.s_data;
                        if (prog.s_last) begin
                            state_d = StErr;
                            err_d   = 1'b1;
                        end else begin
                            state_d = StLo;
                        end
                    end
                end
                StLo: begin
                    if (accept) begin
                        wr_en_d    = 1'b1;
                        wr_data_d  = {hi_q, prog.s_data};
                        wr_addr_d  = inst_cnt_q[ADDR_WIDTH-1:0];
                        inst_cnt_d = inst_cnt_q + CntOne;
                        if (prog.s_last) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else if (inst_cnt_q == LastSlot) begin
                            // last RAM slot just written; more words would wrap
                            state_d = StErr;
                            err_d   = 1'b1;
                        end else begin
                            state_d = StHi;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            hi_q       <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            inst_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            done_q     <= done_d;
            err_q      <= err_d;
            inst_cnt_q <= inst_cnt_d;
        end
    end

    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_en    = wr_en_q;
    assign done     = done_q;
    assign err      = err_q;
    assign inst_cnt = inst_cnt_q;

`ifdef BPF_LOADER_CHECKSUM_EN
    logic [IN_WIDTH-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (load_start) begin
            checksum_d = '0;
        end else if (accept) begin
            checksum_d = checksum_q ^ prog.s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_bpf_code_loader.sv
// Directed bench for bpf_code_loader: full-size instance plus a 4-slot instance for overflow.
module tb_bpf_code_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ls_c = 1'b0;
    logic ls_s = 1'b0;

    always #5 clk = ~clk;

    bpf_code_loader_if #(.IN_WIDTH(32)) ifc ();
    bpf_code_loader_if #(.IN_WIDTH(32)) ifs ();

    logic [9:0]  wa_c;
    logic [63:0] wd_c;
    logic        we_c, busy_c, done_c, err_c;
    logic [10:0] cnt_c;
    logic [1:0]  wa_s;
    logic [63:0] wd_s;
    logic        we_s, busy_s, done_s, err_s;
    logic [2:0]  cnt_s;
`ifdef BPF_LOADER_CHECKSUM_EN
    logic [31:0] cks_c, cks_s;
`endif

    bpf_code_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .IN_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (ls_c),
        .prog       (ifc),
        .wr_addr    (wa_c),
        .wr_data    (wd_c),
        .wr_en      (we_c),
        .busy       (busy_c),
        .done       (done_c),
        .err        (err_c),
        .inst_cnt   (cnt_c)
`ifdef BPF_LOADER_CHECKSUM_EN
        ,
        .checksum   (cks_c)
`endif
    );

    bpf_code_loader #(.ADDR_WIDTH(2), .DATA_WIDTH(64), .IN_WIDTH(32)) dut_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (ls_s),
        .prog       (ifs),
        .wr_addr    (wa_s),
        .wr_data    (wd_s),
        .wr_en      (we_s),
        .busy       (busy_s),
        .done       (done_s),
        .err        (err_s),
        .inst_cnt   (cnt_s)
`ifdef BPF_LOADER_CHECKSUM_EN
        ,
        .checksum   (cks_s)
`endif
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [63:0] wa_q[$];
    logic [63:0] wd_q[$];

    // capture code RAM writes of whichever instance is under test
    bit mon_small = 1'b0;
    always @(negedge clk) begin
        if (!mon_small && we_c) begin
            wa_q.push_back(64'(wa_c));
            wd_q.push_back(wd_c);
        end
        if (mon_small && we_s) begin
            wa_q.push_back(64'(wa_s));
            wd_q.push_back(wd_s);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sm, input bit v, input logic [31:0] w, input bit last);
        if (sm) begin
            ifs.s_valid = v; ifs.s_data = w; ifs.s_last = last;
        end else begin
            ifc.s_valid = v; ifc.s_data = w; ifc.s_last = last;
        end
    endtask

    // Called at a negedge; returns at the negedge after the word is accepted.
    task automatic push(input bit sm, input logic [31:0] w, input bit last, input int gap);
        bit rdy;
        repeat (gap) @(negedge clk);
        drive(sm, 1'b1, w, last);
        for (int i = 0; i < 50; i++) begin
            #1;
            rdy = sm ? ifs.s_ready : ifc.s_ready;
            @(negedge clk);
            if (rdy) begin
                drive(sm, 1'b0, 32'h0, 1'b0);
                return;
            end
        end
        check("push_timeout", 64'd0, 64'd1);
        drive(sm, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic start(input bit sm);
        wa_q.delete();
        wd_q.delete();
        mon_small = sm;
        if (sm) ls_s = 1'b1; else ls_c = 1'b1;
        @(negedge clk);
        ls_s = 1'b0;
        ls_c = 1'b0;
    endtask

    task automatic check_six(input string t);
        check({t, "_nwr"}, 64'(wa_q.size()), 64'd3);
        if (wa_q.size() == 3) begin
            check({t, "_a0"}, wa_q[0], 64'd0);
            check({t, "_d0"}, wd_q[0], 64'hC0DE0000_C0DE0001);
            check({t, "_a1"}, wa_q[1], 64'd1);
            check({t, "_d1"}, wd_q[1], 64'hC0DE0002_C0DE0003);
            check({t, "_a2"}, wa_q[2], 64'd2);
            check({t, "_d2"}, wd_q[2], 64'hC0DE0004_C0DE0005);
        end
        check({t, "_done"}, 64'(done_c), 64'd1);
        check({t, "_err"},  64'(err_c),  64'd0);
        check({t, "_cnt"},  64'(cnt_c),  64'd3);
        check({t, "_busy"}, 64'(busy_c), 64'd0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy_c), 64'd0);
        check("rst_cnt",  64'(cnt_c),  64'd0);
        check("rst_wd",   wd_c,        64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1 check("idle_ready", 64'(ifc.s_ready), 64'd0);
        @(negedge clk);

        // 1: six back-to-back words
        start(1'b0);
        check("t1_busy", 64'(busy_c), 64'd1);
        for (int i = 0; i < 6; i++) push(1'b0, 32'hC0DE0000 + 32'(i), i == 5, 0);
        @(negedge clk);
        check_six("t1");

        // 2: odd word count
        start(1'b0);
        for (int i = 0; i < 3; i++) push(1'b0, 32'hC0DE0000 + 32'(i), i == 2, 0);
        @(negedge clk);
        check("t2_nwr", 64'(wa_q.size()), 64'd1);
        if (wa_q.size() == 1) begin
            check("t2_a0", wa_q[0], 64'd0);
            check("t2_d0", wd_q[0], 64'hC0DE0000_C0DE0001);
        end
        check("t2_err",  64'(err_c),  64'd1);
        check("t2_done", 64'(done_c), 64'd0);
        check("t2_cnt",  64'(cnt_c),  64'd1);

        // 3: overflow of a 4-slot RAM
        start(1'b1);
        for (int i = 0; i < 8; i++) push(1'b1, 32'h50000000 + 32'(i), 1'b0, 0);
        check("t3_err_at8", 64'(err_s), 64'd1);
        drive(1'b1, 1'b1, 32'h50000008, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 check("t3_ready", 64'(ifs.s_ready), 64'd0);
            @(negedge clk);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        check("t3_nwr", 64'(wa_q.size()), 64'd4);
        if (wa_q.size() == 4) begin
            check("t3_a3", wa_q[3], 64'd3);
            check("t3_d3", wd_q[3], 64'h50000006_50000007);
        end
        check("t3_cnt",  64'(cnt_s),  64'd4);
        check("t3_done", 64'(done_s), 64'd0);

        // 4: same program as 1 with random valid gaps
        start(1'b0);
        for (int i = 0; i < 6; i++)
            push(1'b0, 32'hC0DE0000 + 32'(i), i == 5, int'($urandom_range(0, 2)));
        @(negedge clk);
        check_six("t4");

        // 5: abort while in LO with a word offered
        start(1'b0);
        for (int i = 0; i < 3; i++) push(1'b0, 32'hC0DE0000 + 32'(i), 1'b0, 0);
        @(negedge clk);
        wa_q.delete();
        wd_q.delete();
        ls_c = 1'b1;
        drive(1'b0, 1'b1, 32'hDEAD0000, 1'b0);
        #1 check("t5_ready", 64'(ifc.s_ready), 64'd0);
        @(negedge clk);
        ls_c = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        check("t5_cnt",  64'(cnt_c),  64'd0);
        check("t5_busy", 64'(busy_c), 64'd1);
        for (int i = 0; i < 4; i++) push(1'b0, 32'h70000000 + 32'(i), i == 3, 0);
        @(negedge clk);
        check("t5_nwr", 64'(wa_q.size()), 64'd2);
        if (wa_q.size() == 2) begin
            check("t5_a0", wa_q[0], 64'd0);
            check("t5_d0", wd_q[0], 64'h70000000_70000001);
        end

        // 6: reset mid-load
        start(1'b0);
        for (int i = 0; i < 3; i++) push(1'b0, 32'hC0DE0000 + 32'(i), 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check("t6_busy", 64'(busy_c), 64'd0);
        check("t6_we",   64'(we_c),   64'd0);
        check("t6_cnt",  64'(cnt_c),  64'd0);
        check("t6_wa",   64'(wa_c),   64'd0);
        check("t6_wd",   wd_c,        64'd0);
        check("t6_rdy",  64'(ifc.s_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`ifdef BPF_LOADER_CHECKSUM_EN
        check("t6_cks_rst", 64'(cks_c), 64'd0);
        start(1'b0);
        push(1'b0, 32'h1, 1'b0, 0);
        push(1'b0, 32'h2, 1'b0, 0);
        push(1'b0, 32'h4, 1'b0, 0);
        push(1'b0, 32'h8, 1'b1, 0);
        check("t6_cks_done", 64'(done_c), 64'd1);
        check("t6_cks", 64'(cks_c), 64'hF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
